// File: rtl/fb_pkg.sv
// Shared framebuffer geometry, pixel format and write-FSM state type.
// Reused by the VGA read-address logic and the cursor logic.
package fb_pkg;

   localparam int H_RES    = 640;
   localparam int V_RES    = 480;
   localparam int FB_DEPTH = H_RES * V_RES;
   localparam int ADDR_W   = 20;
   localparam int DATA_W   = 9;

   localparam logic [DATA_W-1:0] CLEAR_COLOR = 9'h1FF;

   typedef enum logic [0:0] {
      ST_CLEAR = 1'b0,
      ST_RUN   = 1'b1
   } fb_state_t;

endpackage

// File: rtl/fb_clear_seq.sv
// Full-screen clear address sequencer: walks 0..DEPTH-1 while enabled,
// wraps to 0 after the last address and flags that cycle with done.
module fb_clear_seq #(
   parameter int ADDR_W = fb_pkg::ADDR_W,
   parameter int DEPTH  = fb_pkg::FB_DEPTH
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              en,
   output logic [ADDR_W-1:0] count,
   output logic              done
);

   import fb_pkg::*;

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

   logic last;

   assign last = (count == LAST_ADDR);
   assign done = en & last;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (en) begin
         count <= last ? '0 : count + ADDR_W'(1);
      end
   end

endmodule

// File: rtl/fb_write_arbiter.sv
// Framebuffer write port owner: full-screen clear sequencer plus a
// round-robin arbiter between the brush and aux (fill/shape) requesters.
module fb_write_arbiter #(
   parameter int H_RES  = fb_pkg::H_RES,
   parameter int V_RES  = fb_pkg::V_RES,
   parameter int ADDR_W = fb_pkg::ADDR_W,
   parameter int DATA_W = fb_pkg::DATA_W,
   parameter logic [DATA_W-1:0] CLEAR_COLOR = fb_pkg::CLEAR_COLOR
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clear_req,
   input  logic              brush_req,
   input  logic [ADDR_W-1:0] brush_addr,
   input  logic [DATA_W-1:0] brush_data,
   output logic              brush_ack,
   input  logic              aux_req,
   input  logic [ADDR_W-1:0] aux_addr,
   input  logic [DATA_W-1:0] aux_data,
   output logic              aux_ack,
   output logic              we,
   output logic [ADDR_W-1:0] waddr,
   output logic [DATA_W-1:0] wdata,
   output logic              initialized,
   output logic              busy,
   output logic              addr_err
);

   import fb_pkg::*;

   localparam int DEPTH = H_RES * V_RES;
   localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);

   fb_state_t         state;
   logic [ADDR_W-1:0] count;
   logic              clr_done;
   logic              rr_aux;
   logic              b_elig;
   logic              a_elig;
   logic              gnt_b;
   logic              gnt_a;
   logic              gnt;
   logic              in_rng;
   logic [ADDR_W-1:0] sel_addr;
   logic [DATA_W-1:0] sel_data;

   fb_clear_seq #(
      .ADDR_W (ADDR_W),
      .DEPTH  (DEPTH)
   ) u_clear_seq (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (state == ST_CLEAR),
      .count (count),
      .done  (clr_done)
   );

   // A requester acked this cycle sits out the next edge.
   assign b_elig = brush_req & ~brush_ack;
   assign a_elig = aux_req & ~aux_ack;

   assign gnt_b = b_elig & (~a_elig | ~rr_aux);
   assign gnt_a = a_elig & ~gnt_b;
   assign gnt   = gnt_b | gnt_a;

   assign sel_addr = gnt_b ? brush_addr : aux_addr;
   assign sel_data = gnt_b ? brush_data : aux_data;
   assign in_rng   = (sel_addr < DEPTH_A);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= ST_CLEAR;
         busy        <= 1'b1;
         initialized <= 1'b0;
         we          <= 1'b0;
         waddr       <= '0;
         wdata       <= '0;
         brush_ack   <= 1'b0;
         aux_ack     <= 1'b0;
         addr_err    <= 1'b0;
         rr_aux      <= 1'b0;
      end else begin
         busy        <= (state == ST_CLEAR);
         initialized <= initialized | (state == ST_RUN);
         unique case (state)
            ST_CLEAR: begin
               we        <= 1'b1;
               waddr     <= count;
               wdata     <= CLEAR_COLOR;
               brush_ack <= 1'b0;
               aux_ack   <= 1'b0;
               addr_err  <= 1'b0;
               if (clr_done) begin
                  state <= ST_RUN;
               end
            end
            ST_RUN: begin
               brush_ack <= gnt_b;
               aux_ack   <= gnt_a;
               we        <= gnt & in_rng;
               addr_err  <= gnt & ~in_rng;
               if (gnt) begin
                  waddr  <= sel_addr;
                  wdata  <= sel_data;
                  rr_aux <= gnt_b;
               end
               if (clear_req) begin
                  state <= ST_CLEAR;
               end
            end
         endcase
      end
   end

endmodule
